// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Assembles a host byte stream (MSB first) into 32-bit instruction words and
//   writes them sequentially into the instruction memory write port. The CPU is
//   held in reset while a load is in progress, and released once the halt word
//   has been written (or the memory has filled up).
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     defined   -> one trailing checksum byte (XOR of all program bytes) is
//                  expected after the halt word; chk_err flags a mismatch.
//     undefined -> halt word write goes straight to DONE; chk_err tied to 0.
//
// Ports
//   clk, rst          clock (rising edge), async active-high reset
//   start             one-cycle load request, honoured only in IDLE/DONE
//   in_valid/in_data  byte source; in_ready is the accept handshake
//   mem_a/mem_d/mem_we  instruction memory write port, one strobe per word
//   cpu_hold, busy    high for the whole session
//   done              sticky completion flag, cleared by the next start
//   overflow          memory filled without seeing the halt word
//   word_count        words written this session
//   chk_err           checksum mismatch (feature only)
module instr_mem_loader #(
  parameter int          ADDR_W    = 10,
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] HALT_WORD = 32'hFC000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_d,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count,
  output logic              chk_err
);

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  state_t      state, state_n;
  logic [1:0]  byte_idx;
  logic        accept;
  logic        start_ok;
  logic        in_ready_d, mem_we_d, busy_d, done_d;

  // in_ready is a registered copy of "state is RECV/CHECK", so the handshake
  // can use it directly.
  assign accept   = in_valid & in_ready;
  assign start_ok = start & ((state == IDLE) | (state == DONE));

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start) state_n = RECV;
      RECV:       if (accept && byte_idx == 2'd3) state_n = WRITE;
      WRITE: begin
        // mem_d holds the word being written this cycle
        if (mem_d == HALT_WORD)
`ifdef LOADER_CHECKSUM_EN
          state_n = CHECK;
`else
          state_n = DONE;
`endif
        else if (mem_a == LAST_A) state_n = DONE;
        else                      state_n = RECV;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK:      if (accept) state_n = DONE;
`endif
      default:    state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  // Decoded from the next state and registered below, so every flag changes
  // on the same edge as the state it belongs to.
  always_comb begin
    in_ready_d = (state_n == RECV);
`ifdef LOADER_CHECKSUM_EN
    in_ready_d = in_ready_d | (state_n == CHECK);
`endif
    mem_we_d   = (state_n == WRITE);
    busy_d     = (state_n != IDLE) && (state_n != DONE);
    done_d     = (state_n == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b0;
      mem_we   <= 1'b0;
      busy     <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
    end else begin
      in_ready <= in_ready_d;
      mem_we   <= mem_we_d;
      busy     <= busy_d;
      cpu_hold <= busy_d;
      done     <= done_d;
    end
  end

  // ---------------------------------------------------------------- datapath
  // mem_d doubles as the byte shift register; mem_a is the write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_a      <= '0;
      mem_d      <= '0;
      byte_idx   <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else if (start_ok) begin
      mem_a      <= '0;
      mem_d      <= '0;
      byte_idx   <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        RECV: if (accept) begin
          mem_d    <= {mem_d[23:0], in_data};
          byte_idx <= byte_idx + 2'd1;   // wraps to 0 after the 4th byte
        end
        WRITE: begin
          word_count <= word_count + 1'b1;
          if (mem_d != HALT_WORD) begin
            // never wrap: the last address ends the session instead
            if (mem_a == LAST_A) overflow <= 1'b1;
            else                 mem_a    <= mem_a + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] xor_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xor_acc <= '0;
      chk_err <= 1'b0;
    end else if (start_ok) begin
      xor_acc <= '0;
      chk_err <= 1'b0;
    end else begin
      if (state == RECV && accept)  xor_acc <= xor_acc ^ in_data;
      if (state == CHECK && accept) chk_err <= (in_data != xor_acc);
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader. A byte driver randomly withholds
// in_valid, a negedge monitor records every write strobe, and a reference
// model derives the expected write list, word count, overflow and checksum
// straight from the byte list.
module tb_instr_mem_loader;
  localparam int          ADDR_W = 10;
  localparam int          DEPTH  = 1024;
  localparam logic [31:0] HALT   = 32'hFC000000;

  logic              clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [7:0]        in_data = 0;
  logic              in_ready, mem_we, cpu_hold, busy, done, overflow, chk_err;
  logic [ADDR_W-1:0] mem_a;
  logic [31:0]       mem_d;
  logic [ADDR_W:0]   word_count;

  int total = 0, bad = 0;

  logic [7:0]  byte_q[$];
  int          exp_a[$];
  logic [31:0] exp_d[$];
  bit          exp_ovf, exp_halt, exp_chk;
  logic [7:0]  exp_x;
  int          wr_a[$];
  logic [31:0] wr_d[$];

  instr_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .HALT_WORD(HALT)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .overflow(overflow),
    .word_count(word_count), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we === 1'b1) begin
    wr_a.push_back(int'(mem_a));
    wr_d.push_back(mem_d);
  end

  // ---------------------------------------------------------------- model
  function automatic logic [31:0] rnd_word();
    logic [31:0] w = $urandom;
    if (w == HALT) w = w ^ 32'h1;
    return w;
  endfunction

  task automatic push_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) byte_q.push_back(w[8*k +: 8]);
  endtask

  // Memory is filled word by word from address 0 until the halt word is seen
  // or DEPTH words have been written.
  task automatic build_expect();
    logic [31:0] w;
    exp_a.delete(); exp_d.delete();
    exp_ovf = 0; exp_halt = 0; exp_x = 0;
    for (int i = 0; i + 3 < byte_q.size(); i += 4) begin
      w = {byte_q[i], byte_q[i+1], byte_q[i+2], byte_q[i+3]};
      exp_x = exp_x ^ byte_q[i] ^ byte_q[i+1] ^ byte_q[i+2] ^ byte_q[i+3];
      exp_a.push_back(exp_a.size());
      exp_d.push_back(w);
      if (w == HALT) begin exp_halt = 1; break; end
      if (exp_a.size() == DEPTH) begin exp_ovf = 1; break; end
    end
  endtask

  // ---------------------------------------------------------------- driver
  // Returns at a negedge with the byte presented and in_ready high, so the
  // following rising edge accepts it.
  task automatic send_byte(input logic [7:0] b, input int p_idle);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if ($urandom_range(99) < p_idle) begin
        in_valid = 0; in_data = 8'($urandom);
      end else begin
        in_valid = 1; in_data = b;
        if (in_ready === 1'b1) return;
      end
    end
    total++; bad++;
    $display("FAIL send_byte timeout: in_ready=%b required 1", in_ready);
  endtask

  task automatic start_load();
    build_expect();
    wr_a.delete(); wr_d.delete();
    @(negedge clk); start = 1; in_valid = 1; in_data = 8'hEE;
    @(negedge clk); start = 0; in_valid = 0;
    total++;
    if ({busy, cpu_hold, done} !== 3'b110) begin
      bad++; $display("FAIL start_flags: busy/hold/done=%b required 110", {busy, cpu_hold, done});
    end
  endtask

  task automatic send_range(input int lo, input int hi, input int p_idle);
    for (int i = lo; i < hi; i++) send_byte(byte_q[i], p_idle);
  endtask

  // chk_val < 0 sends the correct checksum
  task automatic finish_load(input string tag, input int p_idle, input int chk_val);
    int n, first;
    logic [7:0] cb;
    exp_chk = 0;
`ifdef LOADER_CHECKSUM_EN
    if (exp_halt) begin
      cb = (chk_val < 0) ? exp_x : 8'(chk_val);
      exp_chk = (cb != exp_x);
      send_byte(cb, p_idle);
    end
`endif
    @(negedge clk); in_valid = 0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL %s done: got %b required 1", tag, done); end
    total++;
    if (wr_a.size() != exp_a.size()) begin
      bad++; $display("FAIL %s write_count: got %0d required %0d", tag, wr_a.size(), exp_a.size());
    end
    first = -1;
    for (int i = 0; i < wr_a.size() && i < exp_a.size(); i++)
      if (first < 0 && (wr_a[i] != exp_a[i] || wr_d[i] !== exp_d[i])) first = i;
    total++;
    if (first >= 0) begin
      bad++; $display("FAIL %s write[%0d]: got a=%0d d=%h required a=%0d d=%h", tag, first,
                      wr_a[first], wr_d[first], exp_a[first], exp_d[first]);
    end
    total++;
    if (word_count !== (ADDR_W+1)'(exp_a.size())) begin
      bad++; $display("FAIL %s word_count: got %0d required %0d", tag, word_count, exp_a.size());
    end
    total++;
    if (overflow !== exp_ovf) begin
      bad++; $display("FAIL %s overflow: got %b required %b", tag, overflow, exp_ovf);
    end
    total++;
    if ({busy, cpu_hold, in_ready} !== 3'b000) begin
      bad++; $display("FAIL %s idle_flags: busy/hold/ready=%b required 000", tag, {busy, cpu_hold, in_ready});
    end
    total++;
    if (chk_err !== exp_chk) begin
      bad++; $display("FAIL %s chk_err: got %b required %b", tag, chk_err, exp_chk);
    end
    // host keeps offering bytes after the session: nothing more may be written
    n = wr_a.size();
    repeat (10) begin @(negedge clk); in_valid = 1; in_data = 8'($urandom); end
    @(negedge clk); in_valid = 0;
    total++;
    if (wr_a.size() != n || done !== 1'b1) begin
      bad++; $display("FAIL %s after_done: writes=%0d done=%b required %0d 1", tag, wr_a.size(), done, n);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    #1;
    total++;
    if ({in_ready, mem_we, cpu_hold, busy, done, overflow, chk_err} !== 7'b0) begin
      bad++; $display("FAIL reset_flags: got %b required 0",
                      {in_ready, mem_we, cpu_hold, busy, done, overflow, chk_err});
    end
    total++;
    if (mem_a !== '0 || mem_d !== '0 || word_count !== '0) begin
      bad++; $display("FAIL reset_data: a=%0d d=%h wc=%0d required 0 0 0", mem_a, mem_d, word_count);
    end
    @(negedge clk); rst = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_addi();
    byte_q.delete();
    push_word(32'h2001000A); push_word(32'h20220014); push_word(HALT);
    start_load();
    send_range(0, byte_q.size(), 0);
    finish_load("addi", 0, -1);
  endtask

  task automatic test_random_valid();
    for (int r = 0; r < 3; r++) begin
      byte_q.delete();
      push_word(rnd_word()); push_word(rnd_word()); push_word(HALT);
      start_load();
      send_range(0, byte_q.size(), 60);
      finish_load("rand_valid", 60, -1);
    end
  endtask

  task automatic test_overflow();
    byte_q.delete();
    for (int i = 0; i < DEPTH; i++) push_word(rnd_word());
    start_load();
    send_range(0, byte_q.size(), 0);
    finish_load("overflow", 0, -1);
  endtask

  task automatic test_reset_mid();
    byte_q.delete();
    push_word(rnd_word()); push_word(rnd_word()); push_word(HALT);
    start_load();
    send_range(0, 6, 20);
    @(negedge clk); in_valid = 0; rst = 1;
    #1;
    total++;
    if ({in_ready, mem_we, cpu_hold, busy, done, overflow, chk_err} !== 7'b0) begin
      bad++; $display("FAIL rst_mid_flags: got %b required 0",
                      {in_ready, mem_we, cpu_hold, busy, done, overflow, chk_err});
    end
    total++;
    if (mem_a !== '0 || mem_d !== '0 || word_count !== '0) begin
      bad++; $display("FAIL rst_mid_data: a=%0d d=%h wc=%0d required 0 0 0", mem_a, mem_d, word_count);
    end
    @(negedge clk); rst = 0;
    byte_q.delete();
    push_word(rnd_word()); push_word(HALT);
    start_load();
    send_range(0, byte_q.size(), 20);
    finish_load("rst_reload", 20, -1);
  endtask

  task automatic test_checksum();
    byte_q.delete();
    push_word(32'h2001000A); push_word(HALT);
    start_load();
    send_range(0, byte_q.size(), 30);
    finish_load("chk_good", 30, 8'hD7);
    start_load();
    send_range(0, byte_q.size(), 30);
    finish_load("chk_bad", 30, 8'h00);
  endtask

  task automatic test_start_busy();
    byte_q.delete();
    push_word(rnd_word()); push_word(rnd_word()); push_word(HALT);
    start_load();
    send_range(0, 5, 0);
    @(negedge clk); in_valid = 0; start = 1;
    @(negedge clk); start = 0;
    total++;
    if (mem_a !== 1 || word_count !== 1 || busy !== 1'b1) begin
      bad++; $display("FAIL start_busy: a=%0d wc=%0d busy=%b required 1 1 1", mem_a, word_count, busy);
    end
    send_range(5, byte_q.size(), 0);
    finish_load("start_busy", 0, -1);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_random_valid();
    test_checksum();
    test_start_busy();
    test_reset_mid();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Byte-stream loader that assembles incoming bytes into 32-bit instruction words and writes them sequentially into the instruction memory's write port (address, data, write-enable). It sits between a host byte source (UART receiver or testbench) and the instruction memory. While it loads, it holds the processor in reset, and it releases the processor once the halt word has been written.

## Interface
Parameters:
- ADDR_W, 10, instruction memory address width
- DEPTH, 1024, number of words; the last writable address is DEPTH-1
- HALT_WORD, 32'hFC000000, end-of-program marker word

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a load session; ignored unless in IDLE or DONE
- in_valid  in  1  byte available on in_data
- in_data  in  8  program byte, most significant byte of each word first
- in_ready  out  1  loader accepts a byte this cycle
- mem_a  out  ADDR_W  write address to instruction memory
- mem_d  out  32  write data to instruction memory
- mem_we  out  1  write strobe, one cycle per word
- cpu_hold  out  1  holds the processor in reset while a load is in progress
- busy  out  1  high from start until DONE
- done  out  1  sticky load-complete flag, cleared by the next start
- overflow  out  1  memory filled without a halt word being received
- word_count  out  ADDR_W+1  number of words written in this session
- chk_err  out  1  checksum mismatch; driven 0 when the checksum feature is compiled out

## Operation
- States: IDLE, RECV, WRITE, CHECK (feature only), DONE.
- IDLE/DONE: on start, clear the address, byte index, shift register, word_count, overflow, chk_err and done, then go to RECV. cpu_hold goes high.
- RECV: in_ready=1. A byte is accepted when in_valid and in_ready are both high. It shifts in as {word[23:0], in_data}. byte_idx counts 0..3. Acceptance of the 4th byte moves the block to WRITE.
- WRITE: mem_we=1 with mem_a = current address and mem_d = the assembled word. word_count is incremented.
  - If the word equals HALT_WORD, go to CHECK (feature on) or DONE.
  - Else, if the address equals DEPTH-1, set overflow=1 and go to DONE.
  - Else, increment the address and return to RECV.
- CHECK: in_ready=1. Accept one byte and compare it to the XOR of all program bytes received in this session. Set chk_err on mismatch, then go to DONE.
- DONE: done=1, busy=0, cpu_hold=0, in_ready=0. A new start reloads from address 0.
- Bytes presented outside RECV/CHECK are not accepted, because in_ready=0 there.

## Timing
- Reset values: in_ready=0, mem_a=0, mem_d=0, mem_we=0, cpu_hold=0, busy=0, done=0, overflow=0, word_count=0, chk_err=0. The state is IDLE.
- Reset asserted mid-load aborts the session immediately with the values above. Partially assembled bytes are discarded. Words already written stay in memory.
- start is sampled at a clock edge. busy and cpu_hold are high from the following cycle.
- mem_we pulses in the cycle after the 4th byte of a word is accepted. The memory captures the write at the end of that cycle.
- Throughput: at most 1 word per 5 cycles (4 accept cycles plus 1 WRITE cycle). in_ready is low during WRITE.
- done, overflow and chk_err rise in the cycle the state enters DONE. cpu_hold falls in the same cycle.
- start asserted while in RECV/WRITE/CHECK is ignored. An in_valid coincident with start is not accepted.
- All outputs are registered.

## Configuration
- LOADER_CHECKSUM_EN defined: the CHECK state exists. One trailing checksum byte is expected after the halt word, and chk_err reports a mismatch.
- LOADER_CHECKSUM_EN undefined: there is no CHECK state. The halt word write goes directly to DONE, and chk_err is tied to 0.

## Test plan
- Load with addi words 0x2001000A and 0x2022 0014 followed by 0xFC000000:
  - Three mem_we pulses occur at addresses 0, 1, 2 with matching data.
  - word_count=3, done=1, overflow=0.
- in_valid toggles randomly during a 2-word load:
  - Only handshaken bytes are assembled.
  - mem_d matches the sent words exactly.
- Stream 1024 non-halt words:
  - The last write is at address 1023.
  - overflow=1, done=1, word_count=1024.
  - There is no write at a wrapped address 0.
- Assert rst after the 2nd byte of word 1:
  - All outputs return to reset values immediately.
  - A subsequent start reloads from address 0.
- With LOADER_CHECKSUM_EN, send bytes 20 01 00 0A FC 00 00 00 then a checksum byte:
  - A checksum of 0xD7 gives chk_err=0.
  - A checksum of 0x00 gives chk_err=1.
- Pulse start while busy:
  - The pulse is ignored.
  - Address and word_count are unchanged.
